diff_scheduler: RTL and testbench

Time-multiplexed front end for the FM demodulator's phase-to-frequency differentiation. It shares a single subtractor among `channels` phase streams, such as several tuned stations or diversity paths. Each requester is arbitrated round-robin with a valid/ready handshake. For the granted channel it computes `in - previous sample of that channel`, keeping one history register per channel. Output is a single registered stream, tagged with the channel index, that feeds the audio filter chain.

---
 rtl/diff_scheduler_pkg.sv | 15 +
 rtl/diff_scheduler_if.sv | 30 +++
 rtl/diff_scheduler_rr_arbiter.sv | 53 +++++
 rtl/diff_scheduler.sv | 112 +++++++++++
 tb/tb_diff_scheduler.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/diff_scheduler_pkg.sv
// Shared types and sizing helpers for the diff_scheduler codebase slice.
package diff_sched_pkg;

  localparam int MAX_CHANNELS = 16;

  // Channel index width; a single channel still needs one bit of tag.
  function automatic int chan_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CHAN_W = chan_w(MAX_CHANNELS);

  typedef logic [CHAN_W-1:0] chan_t;

endpackage

// File: rtl/diff_scheduler_if.sv
// Request/response bundle between phase sources, diff_scheduler and the audio filter chain.
// Handshake: a word moves when valid and ready are both high at a rising clk edge;
// valid never waits on ready, and a raised valid holds its data until taken.
interface diff_scheduler_if #(
  parameter int width    = 16,
  parameter int channels = 2
) ();

  localparam int CW = diff_sched_pkg::chan_w(channels);

  logic [channels-1:0]            in_valid;
  logic [channels-1:0][width-1:0] in_data;
  logic [channels-1:0]            in_ready;
  logic                           out_valid;
  logic [width-1:0]               out_data;
  logic [CW-1:0]                  out_chan;
  logic                           out_ready;
  logic [CW-1:0]                  dbg_ptr;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_chan, dbg_ptr
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_chan, dbg_ptr
  );

endinterface

// File: rtl/diff_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, then moves ptr past it.
module rr_arbiter
  import diff_sched_pkg::*;
#(
  parameter  int channels = 2,
  localparam int CW       = chan_w(channels)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [channels-1:0] req,
  input  logic                advance,
  output logic [channels-1:0] grant,
  output logic [CW-1:0]       grant_idx,
  output logic [CW-1:0]       ptr
);

  logic [CW-1:0] ptr_q, ptr_d;
  logic [CW:0]   sum;
  logic [CW-1:0] idx;
  logic          found;

  // Search from ptr upward; one extra bit lets ptr+k wrap for non-power-of-two counts.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int k = 0; k < channels; k++) begin
      sum = {1'b0, ptr_q} + (CW+1)'(k);
      if (sum >= (CW+1)'(channels)) sum = sum - (CW+1)'(channels);
      idx = sum[CW-1:0];
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance) ptr_d = (grant_idx == CW'(channels - 1)) ? '0 : grant_idx + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/diff_scheduler.sv
// Shared-subtractor phase differentiator: out = in[c] - hist[c] for the round-robin granted channel.
// Optional DIFF_SCHED_PRIME_EN suppresses the start-up step by outputting 0 on each channel's first sample.
module diff_scheduler
  import diff_sched_pkg::*;
#(
  parameter int width    = 16,
  parameter int channels = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  diff_scheduler_if.slave   bus
);

  localparam int CW = chan_w(channels);

  logic                accept;
  logic                xfer;
  logic [channels-1:0] grant;
  logic [CW-1:0]       grant_idx;
  logic [CW-1:0]       ptr;

  logic [width-1:0]    hist_q [channels];
  logic [width-1:0]    hist_d [channels];
  logic [width-1:0]    sel_data;
  logic [width-1:0]    sel_hist;
  logic [width-1:0]    diff;

  logic                out_valid_q, out_valid_d;
  logic [width-1:0]    out_data_q,  out_data_d;
  logic [CW-1:0]       out_chan_q,  out_chan_d;

  // Reset is folded in so in_ready reads 0 while reset is held, even with requests present.
  assign accept       = !reset && !clear && (!out_valid_q || bus.out_ready);
  assign xfer         = accept && (|grant);
  assign bus.in_ready = grant & {channels{accept}};

  rr_arbiter #(.channels(channels)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (bus.in_valid),
    .advance   (xfer),
    .grant     (grant),
    .grant_idx (grant_idx),
    .ptr       (ptr)
  );

  assign sel_data = bus.in_data[grant_idx];
  assign sel_hist = hist_q[grant_idx];

`ifdef DIFF_SCHED_PRIME_EN
  logic [channels-1:0] primed_q, primed_d;

  always_comb begin
    primed_d = primed_q;
    if (clear)     primed_d = '0;
    else if (xfer) primed_d[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) primed_q <= '0;
    else       primed_q <= primed_d;
  end

  assign diff = primed_q[grant_idx] ? sel_data - sel_hist : '0;
`else
  // Modular subtraction is intended: phase wraps at +/-pi.
  assign diff = sel_data - sel_hist;
`endif

  always_comb begin
    for (int i = 0; i < channels; i++) hist_d[i] = hist_q[i];
    if (clear) begin
      for (int i = 0; i < channels; i++) hist_d[i] = '0;
    end else if (xfer) begin
      hist_d[grant_idx] = sel_data;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = diff;
      out_chan_d  = grant_idx;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < channels; i++) hist_q[i] <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
    end else begin
      for (int i = 0; i < channels; i++) hist_q[i] <= hist_d[i];
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_chan  = out_chan_q;
  assign bus.dbg_ptr   = ptr;

endmodule

// File: tb/tb_diff_scheduler.sv
// Directed bench for diff_scheduler (2 channels, 16 bits) with a reference model and scoreboard.
module tb_diff_scheduler;
  import diff_sched_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic clear;
  int   checks = 0;
  int   failures = 0;

  diff_scheduler_if #(.width(16), .channels(2)) bus ();

  diff_scheduler #(.width(16), .channels(2)) dut (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  logic [15:0] src_q [2][$];
  logic [16:0] exp_q [$];
  logic [16:0] obs_q [$];
  logic [16:0] lit_q [$];

  int          m_ptr;
  logic        m_valid;
  logic [15:0] m_hist [2];
  logic        m_primed [2];
  int          g;
  logic        acc;
  logic [1:0]  er;
  logic [15:0] dv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] mk(input int ch, input int d);
    logic [15:0] dd;
    dd = 16'(d);
    return {1'(ch), dd};
  endfunction

  // Driver: present the head of each channel's source queue.
  always @(posedge clk) begin
    #1;
    for (int c = 0; c < 2; c++) begin
      bus.in_valid[c] = (src_q[c].size() > 0);
      bus.in_data[c]  = (src_q[c].size() > 0) ? src_q[c][0] : 16'h0;
    end
  end

  // Model + scoreboard, evaluated mid-cycle for the edge that follows.
  always @(negedge clk) begin
    if (reset) begin
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
      chk("rst_out_data", 32'(bus.out_data), 32'd0);
      chk("rst_out_chan", 32'(bus.out_chan), 32'd0);
      m_valid = 1'b0;
      m_ptr   = 0;
      for (int c = 0; c < 2; c++) begin
        m_hist[c]   = 16'h0;
        m_primed[c] = 1'b0;
      end
      exp_q.delete();
    end else begin
      chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
      if (m_valid) begin
        if (exp_q.size() == 0) chk("sb_underflow", 32'(exp_q.size()), 32'd1);
        else begin
          chk("out_word", 32'({bus.out_chan, bus.out_data}), 32'(exp_q[0]));
          if (bus.out_ready) begin
            obs_q.push_back({bus.out_chan, bus.out_data});
            void'(exp_q.pop_front());
          end
        end
      end
      acc = !clear && (!m_valid || bus.out_ready);
      g   = -1;
      for (int k = 0; k < 2; k++) begin
        if (g < 0 && bus.in_valid[(m_ptr + k) % 2]) g = (m_ptr + k) % 2;
      end
      er = 2'b00;
      if (acc && g >= 0) er[g] = 1'b1;
      chk("in_ready", 32'(bus.in_ready), 32'(er));
      if (acc && g >= 0) begin
        dv = bus.in_data[g] - m_hist[g];
`ifdef DIFF_SCHED_PRIME_EN
        if (!m_primed[g]) dv = 16'h0;
`endif
        exp_q.push_back({1'(g), dv});
        m_hist[g]   = bus.in_data[g];
        m_primed[g] = 1'b1;
        m_ptr       = (g + 1) % 2;
        m_valid     = 1'b1;
        void'(src_q[g].pop_front());
      end else if (m_valid && bus.out_ready) begin
        m_valid = 1'b0;
      end
      if (clear) begin
        for (int c = 0; c < 2; c++) begin
          m_hist[c]   = 16'h0;
          m_primed[c] = 1'b0;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((src_q[0].size() > 0 || src_q[1].size() > 0 || exp_q.size() > 0 || m_valid) && n < 200) begin
      cyc();
      n++;
    end
    chk(tag, 32'(n < 200), 32'd1);
  endtask

  task automatic check_log(input string tag);
    chk({tag, "_count"}, 32'(obs_q.size()), 32'(lit_q.size()));
    for (int i = 0; i < obs_q.size() && i < lit_q.size(); i++)
      chk(tag, 32'(obs_q[i]), 32'(lit_q[i]));
    obs_q.delete();
    lit_q.delete();
  endtask

  initial begin
    reset = 1'b1;
    clear = 1'b0;
    bus.out_ready = 1'b1;

    // Reset with traffic present, then first sample straight through.
    src_q[0].push_back(16'd100);
    repeat (3) cyc();
    reset = 1'b0;
    wait_idle("t1_idle");
`ifdef DIFF_SCHED_PRIME_EN
    lit_q.push_back(mk(0, 0));
`else
    lit_q.push_back(mk(0, 100));
`endif
    check_log("t1_log");

    // Two channels held valid alternate, each with its own history.
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    src_q[0].push_back(16'd100);
    src_q[0].push_back(16'd150);
    src_q[1].push_back(16'd1000);
    src_q[1].push_back(16'd990);
    wait_idle("t2_idle");
`ifdef DIFF_SCHED_PRIME_EN
    lit_q.push_back(mk(0, 0));
    lit_q.push_back(mk(1, 0));
`else
    lit_q.push_back(mk(0, 100));
    lit_q.push_back(mk(1, 1000));
`endif
    lit_q.push_back(mk(0, 50));
    lit_q.push_back(mk(1, -10));
    check_log("t2_log");

    // Wrap-around of the subtraction.
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    src_q[0].push_back(16'd32000);
    src_q[0].push_back(16'(-32000));
    wait_idle("t3_idle");
`ifdef DIFF_SCHED_PRIME_EN
    lit_q.push_back(mk(0, 0));
`else
    lit_q.push_back(mk(0, 32000));
`endif
    lit_q.push_back(mk(0, 1536));
    check_log("t3_log");

    // Backpressure: one result taken, then three stalled cycles.
    bus.out_ready = 1'b0;
    src_q[1].push_back(16'd7);
    src_q[1].push_back(16'd20);
    src_q[1].push_back(16'd5);
    repeat (5) cyc();
    chk("t4_held_valid", 32'(bus.out_valid), 32'd1);
    chk("t4_src_left", 32'(src_q[1].size()), 32'd2);
    bus.out_ready = 1'b1;
    wait_idle("t4_idle");
`ifdef DIFF_SCHED_PRIME_EN
    lit_q.push_back(mk(1, 0));
`else
    lit_q.push_back(mk(1, 7));
`endif
    lit_q.push_back(mk(1, 13));
    lit_q.push_back(mk(1, -15));
    check_log("t4_log");

    // clear while a result is pending.
    bus.out_ready = 1'b0;
    src_q[0].push_back(16'd33);
    cyc();
    cyc();
    src_q[0].push_back(16'd40);
    cyc();
    clear = 1'b1;
    bus.out_ready = 1'b1;
    cyc();
    clear = 1'b0;
    wait_idle("t5_idle");
    lit_q.push_back(mk(0, 32033));
`ifdef DIFF_SCHED_PRIME_EN
    lit_q.push_back(mk(0, 0));
`else
    lit_q.push_back(mk(0, 40));
`endif
    check_log("t5_log");

    // Reset mid-stream drops the pending result at once.
    bus.out_ready = 1'b0;
    src_q[1].push_back(16'd9);
    cyc();
    cyc();
    chk("t6_pending", 32'(bus.out_valid), 32'd1);
    #1 reset = 1'b1;
    #1 chk("t6_async_drop", 32'(bus.out_valid), 32'd0);
    chk("t6_ptr_zero", 32'(bus.dbg_ptr), 32'd0);
    cyc();
    reset = 1'b0;
    bus.out_ready = 1'b1;
    src_q[0].push_back(16'd5);
    src_q[1].push_back(16'd6);
    wait_idle("t6a_idle");
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    src_q[1].push_back(16'd7);
    wait_idle("t6b_idle");
`ifdef DIFF_SCHED_PRIME_EN
    lit_q.push_back(mk(0, 0));
    lit_q.push_back(mk(1, 0));
    lit_q.push_back(mk(1, 0));
`else
    lit_q.push_back(mk(0, 5));
    lit_q.push_back(mk(1, 6));
    lit_q.push_back(mk(1, 7));
`endif
    check_log("t6_log");

    cyc();
    chk("end_sb_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
